// File: rtl/guess_engine.sv
// guess_engine: hangman game-rule engine.
// Accepts letter guesses (0..25) while ready, checks them against the word's
// letter mask, tracks guessed letters and the wrong-guess count, and resolves
// the game into playing / won / lost. WON and LOST hold until resetn.
// Optional feature: define GUESS_ENGINE_REPEAT_PENALTY_EN to make a repeated
// guess of an absent letter count as a fresh wrong guess.
module guess_engine #(
  parameter int MAX_WRONG = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [4:0]  load_x,
  input  logic [25:0] mask,
  output logic        ready,
  output logic [25:0] guessed_mask,
  output logic [1:0]  game_state,
  output logic        wrong,
  output logic [3:0]  wrong_time
);

  localparam logic [2:0] S_PLAY  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_WON   = 3'd3;
  localparam logic [2:0] S_LOST  = 3'd4;

  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_WON     = 2'b01;
  localparam logic [1:0] GS_LOST    = 2'b10;

  localparam logic [3:0] MAX_WRONG_4 = 4'(MAX_WRONG);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [4:0]  r_letter;
  logic [25:0] r_guessed;
  logic [1:0]  r_game_state;
  logic [1:0]  w_next_game_state;
  logic        r_wrong;
  logic [3:0]  r_wrong_time;

  logic w_accept;
  logic w_repeat;
  logic w_present;
  logic w_count_wrong;
  logic w_count_right;
  logic w_all_found;

  assign w_accept    = (r_state == S_PLAY) && load && (load_x <= 5'd25);
  assign w_repeat    = r_guessed[r_letter];
  assign w_present   = mask[r_letter];
  assign w_all_found = (mask != 26'd0) && ((mask & ~r_guessed) == 26'd0);

`ifdef GUESS_ENGINE_REPEAT_PENALTY_EN
  // Any guess of an absent letter is penalised, repeated or not.
  assign w_count_wrong = !w_present;
`else
  // Repeats are free; only a first guess of an absent letter is penalised.
  assign w_count_wrong = !w_repeat && !w_present;
`endif
  assign w_count_right = !w_repeat && w_present;

  // Next-state logic: PLAY -> CHECK -> EVAL -> {PLAY, WON, LOST}.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_PLAY:  if (w_accept) w_next_state = S_CHECK;
      S_CHECK: w_next_state = S_EVAL;
      S_EVAL: begin
        if (r_wrong_time == MAX_WRONG_4) w_next_state = S_LOST;
        else if (w_all_found)            w_next_state = S_WON;
        else                             w_next_state = S_PLAY;
      end
      S_WON:   w_next_state = S_WON;
      S_LOST:  w_next_state = S_LOST;
      default: w_next_state = S_PLAY;
    endcase
  end

  // Decode of the next state so game_state is registered alongside the FSM.
  always_comb begin
    w_next_game_state = GS_PLAYING;
    if (w_next_state == S_WON)       w_next_game_state = GS_WON;
    else if (w_next_state == S_LOST) w_next_game_state = GS_LOST;
  end

  // FSM state and registered game_state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (!resetn) begin
      r_state      <= S_PLAY;
      r_game_state <= GS_PLAYING;
    end else begin
      r_state      <= w_next_state;
      r_game_state <= w_next_game_state;
    end
  end

  // Latch the accepted letter; it only matters in CHECK, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) r_letter <= load_x;
  end

  // Guess bookkeeping, performed once per accepted guess in CHECK.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_guessed    <= 26'd0;
      r_wrong      <= 1'b0;
      r_wrong_time <= 4'd0;
    end else if (r_state == S_CHECK) begin
      r_guessed[r_letter] <= 1'b1;
      if (w_count_wrong) begin
        r_wrong <= 1'b1;
        // Cap is unreachable in practice (EVAL goes to LOST first).
        if (r_wrong_time != MAX_WRONG_4) r_wrong_time <= r_wrong_time + 4'd1;
      end else if (w_count_right) begin
        r_wrong <= 1'b0;
      end
    end
  end

  assign ready        = (r_state == S_PLAY);
  assign guessed_mask = r_guessed;
  assign game_state   = r_game_state;
  assign wrong        = r_wrong;
  assign wrong_time   = r_wrong_time;

endmodule

// File: tb/tb_guess_engine.sv
// tb_guess_engine: directed self-checking bench for guess_engine
// (default MAX_WRONG = 6).
module tb_guess_engine;

  logic        clk;
  logic        resetn;
  logic        load;
  logic [4:0]  load_x;
  logic [25:0] mask;
  logic        ready;
  logic [25:0] guessed_mask;
  logic [1:0]  game_state;
  logic        wrong;
  logic [3:0]  wrong_time;

  int n_compared;
  int n_mismatched;

  guess_engine dut (
    .clk          (clk),
    .resetn       (resetn),
    .load         (load),
    .load_x       (load_x),
    .mask         (mask),
    .ready        (ready),
    .guessed_mask (guessed_mask),
    .game_state   (game_state),
    .wrong        (wrong),
    .wrong_time   (wrong_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    load   = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".guessed"}, 32'(guessed_mask), 32'h0);
    check({tag, ".wrong"},   32'(wrong),        32'h0);
    check({tag, ".wt"},      32'(wrong_time),   32'h0);
    check({tag, ".gs"},      32'(game_state),   32'h0);
    check({tag, ".ready"},   32'(ready),        32'h1);
  endtask

  // Present one guess at edge t; return after edge t (inputs idle again).
  task automatic present(input logic [4:0] x);
    load   = 1'b1;
    load_x = x;
    step();
    load   = 1'b0;
  endtask

  // Full guess: accept, then wait through CHECK and EVAL (edges t+1, t+2).
  task automatic guess(input logic [4:0] x);
    present(x);
    step();
    step();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn = 1'b1;
    load   = 1'b0;
    load_x = 5'd0;
    mask   = 26'h5;

    // Reset values.
    do_reset();
    check_reset_values("rst");

    // Word A,C: guess A.
    present(5'd0);
    check("a.ready_t", 32'(ready), 32'h0);
    step();
    check("a.guessed_t1", 32'(guessed_mask), 32'h1);
    check("a.wrong_t1",   32'(wrong),        32'h0);
    check("a.ready_t1",   32'(ready),        32'h0);
    step();
    check("a.gs_t2",      32'(game_state),   32'h0);
    check("a.ready_t2",   32'(ready),        32'h1);

    // Guess C -> won.
    guess(5'd2);
    check("c.gs",      32'(game_state),   32'h1);
    check("c.ready",   32'(ready),        32'h0);
    check("c.guessed", 32'(guessed_mask), 32'h5);
    // Further load ignored.
    guess(5'd1);
    check("won.guessed", 32'(guessed_mask), 32'h5);
    check("won.gs",      32'(game_state),   32'h1);
    check("won.wt",      32'(wrong_time),   32'h0);

    // Word A only: six wrong guesses -> lost.
    mask = 26'h1;
    do_reset();
    check_reset_values("rst2");
    for (int i = 1; i <= 6; i++) begin
      present(5'(i));
      step();
      check($sformatf("lose%0d.wt", i),    32'(wrong_time), 32'(i));
      check($sformatf("lose%0d.wrong", i), 32'(wrong),      32'h1);
      step();
      check($sformatf("lose%0d.gs", i),    32'(game_state), (i == 6) ? 32'h2 : 32'h0);
    end
    check("lost.ready", 32'(ready), 32'h0);
    guess(5'd0);
    check("lost.guessed", 32'(guessed_mask), 32'h7E);
    check("lost.gs",      32'(game_state),   32'h2);
    check("lost.wt",      32'(wrong_time),   32'h6);

    // Reset out of LOST; play resumes and A wins.
    do_reset();
    check_reset_values("rst_lost");
    guess(5'd0);
    check("resume.gs", 32'(game_state), 32'h1);

    // Repeat wrong guess B twice.
    mask = 26'h5;
    do_reset();
    guess(5'd1);
    guess(5'd1);
`ifdef GUESS_ENGINE_REPEAT_PENALTY_EN
    check("rep.wt", 32'(wrong_time), 32'h2);
`else
    check("rep.wt", 32'(wrong_time), 32'h1);
`endif
    check("rep.wrong",   32'(wrong),        32'h1);
    check("rep.guessed", 32'(guessed_mask), 32'h2);
    // A right guess clears wrong, count held.
    guess(5'd0);
    check("rep.right_wrong", 32'(wrong), 32'h0);

    // Invalid index dropped.
    do_reset();
    present(5'd27);
    check("inv.ready",   32'(ready),        32'h1);
    step();
    check("inv.guessed", 32'(guessed_mask), 32'h0);
    check("inv.wt",      32'(wrong_time),   32'h0);

    // Loads at t+1 and t+2 dropped while busy.
    load = 1'b1; load_x = 5'd3;
    step();                       // edge t: D accepted
    load_x = 5'd4;
    step();                       // edge t+1: E dropped
    check("busy.guessed_t1", 32'(guessed_mask), 32'h8);
    load_x = 5'd5;
    step();                       // edge t+2: F dropped
    load = 1'b0;
    step();
    check("busy.guessed", 32'(guessed_mask), 32'h8);
    check("busy.wt",      32'(wrong_time),   32'h1);
    check("busy.ready",   32'(ready),        32'h1);

    // Reset in the cycle after a wrong guess is accepted.
    do_reset();
    present(5'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_reset_values("rst_mid");
    step();
    check("rst_mid.guessed_after", 32'(guessed_mask), 32'h0);
    check("rst_mid.wt_after",      32'(wrong_time),   32'h0);
    check("rst_mid.ready_after",   32'(ready),        32'h1);

    // load and reset on the same edge: reset wins.
    resetn = 1'b0; load = 1'b1; load_x = 5'd1;
    step();
    resetn = 1'b1; load = 1'b0;
    step();
    step();
    check("rst_load.guessed", 32'(guessed_mask), 32'h0);
    check("rst_load.wt",      32'(wrong_time),   32'h0);
    check("rst_load.ready",   32'(ready),        32'h1);

    // Play resumes after reset.
    guess(5'd0);
    check("post.guessed", 32'(guessed_mask), 32'h1);
    check("post.gs",      32'(game_state),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/guess_engine.md
# guess_engine

Game-rule engine of the hangman datapath. It sits between the PS/2 keyboard front end, which supplies a one-cycle `load` strobe plus a letter index, and the VGA renderer / HEX display, which consume its outputs. It checks each accepted guess against the current word's letter mask, tracks guessed letters and wrong-guess count, and resolves the game into playing, won or lost.

## Interface
- `MAX_WRONG`, default 6: wrong guesses that end the game; legal 1..15.
- `clk`  in  1  system clock (CLOCK_50 domain).
- `resetn`  in  1  synchronous, active-low reset.
- `load`  in  1  one-cycle strobe: `load_x` holds a new key.
- `load_x`  in  5  letter index, 0 = A … 25 = Z; 26..31 invalid.
- `mask`  in  26  bit i set = letter i occurs in the current word; held stable during a game.
- `ready`  out  1  engine can accept a `load` this cycle.
- `guessed_mask`  out  26  bit i set = letter i has been guessed (right or wrong).
- `game_state`  out  2  00 playing, 01 won, 10 lost; 11 never driven.
- `wrong`  out  1  last accepted guess was wrong; held until the next accepted guess.
- `wrong_time`  out  4  wrong-guess count, saturates at `MAX_WRONG`.

## Operation
- FSM states: PLAY, CHECK, EVAL, WON, LOST. Reset → PLAY.
- PLAY: `ready`=1. A guess is accepted when `load`=1 and `load_x`≤25. On acceptance, `load_x` is latched and the FSM moves to CHECK. Invalid indices are dropped, and the FSM stays in PLAY.
- CHECK: let L be the latched letter.
  - If `guessed_mask[L]`=1 (repeat guess): no mask or count change; `wrong` unchanged. See Configuration for the exception.
  - Otherwise set `guessed_mask[L]`.
    - If `mask[L]`=1: `wrong`←0.
    - If `mask[L]`=0: `wrong`←1 and `wrong_time`←`wrong_time`+1.
  - Next state is EVAL.
- EVAL, in priority order:
  - `wrong_time`==`MAX_WRONG` → LOST.
  - Else `mask`≠0 and (`mask` & ~`guessed_mask`)==0 → WON.
  - Else → PLAY.
  - `mask`==0 never wins.
- WON / LOST are terminal. `ready`=0, all `load` strobes are ignored, and all outputs are frozen until `resetn`=0.
- `game_state` is a registered decode of the FSM: PLAY/CHECK/EVAL=00, WON=01, LOST=10.
- Arithmetic: `wrong_time` is 4-bit unsigned and never exceeds `MAX_WRONG`. An increment at the cap is suppressed; this is unreachable, because EVAL moves to LOST first.

## Timing
- Reset (`resetn` low at a rising edge), effective the next cycle:
  - state=PLAY, `guessed_mask`=0, `wrong_time`=0, `wrong`=0, `game_state`=00, `ready`=1.
  - Reset mid-CHECK or mid-EVAL discards the in-flight guess.
- Accepted `load` at edge t:
  - `guessed_mask`, `wrong` and `wrong_time` update at edge t+1.
  - `game_state` updates at edge t+2.
  - `ready` is low during cycles t+1..t+2 and high again from t+3 if still in PLAY.
- `load` while `ready`=0 is dropped, not queued. The keyboard front end is slower than 3 cycles per key, so no real guess is lost.
- `load` and `resetn`=0 on the same edge: reset wins and the guess is dropped.
- `mask` is sampled combinationally in CHECK and EVAL. Changing it mid-game is undefined; the top-level word select requires a reset.

## Configuration
- `GUESS_ENGINE_REPEAT_PENALTY_EN`:
  - Defined: in CHECK, a repeat guess of a letter absent from the word counts as a fresh wrong guess (`wrong`←1, `wrong_time`+1). A repeat of a present letter still has no effect.
  - Undefined (default): every repeat guess is a no-op apart from the 3-cycle busy window.

## Test plan
- Reset, then `mask`=0x0000005 (A, C), `load_x`=0 → at t+1 `guessed_mask`=0x1, `wrong`=0; at t+2 `game_state`=00.
- Same word, guess A then C → at C's t+2 `game_state`=01 and `ready`=0. A further `load_x`=1 changes nothing.
- `mask`=0x1, guess B,C,D,E,F,G (6 wrong) → `wrong_time` counts 1..6, `wrong`=1; `game_state`=10 at the sixth guess's t+2. A following `load` is ignored.
- Repeat wrong guess B twice → `wrong_time`=1 without the macro, 2 with `GUESS_ENGINE_REPEAT_PENALTY_EN`.
- `load_x`=27, and `load` pulses at t+1 and t+2 after an accepted guess → all dropped; `guessed_mask` shows only the one accepted letter.
- Assert `resetn`=0 in the cycle after a wrong guess is accepted, and in the LOST state → all outputs return to reset values the next cycle, and play resumes.
